// File: rtl/led_ctrl_array.sv
// Multi-channel LED driver: per-channel mode (off/on/slow/fast blink) and PWM duty.
// Latency: one registered stage; led/tick update the edge after their inputs are sampled.
// No backpressure: config writes are accepted every cycle, out-of-range channels dropped.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   cfg_we/cfg_ch     write strobe and channel index for mode/duty update
//   cfg_mode/cfg_duty value written into the addressed channel
//   sync              restarts prescaler, blink and PWM counters (phase alignment)
//   ledOn             global enable, 0 forces every LED dark
//   led               registered LED drive, one bit per channel
//   tick              registered one-cycle pulse per blink tick
module led_ctrl_array #(
  parameter int N_CH       = 8,
  parameter int PWM_BITS   = 4,
  parameter int PRESC_DIV  = 50000,
  parameter int BLINK_BITS = 4,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int PR_W      = $clog2(PRESC_DIV)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  input  logic                sync,
  input  logic                ledOn,
  output logic [N_CH-1:0]     led,
  output logic                tick
);

  logic [1:0]            mode_q [N_CH];
  logic [1:0]            mode_d [N_CH];
  logic [PWM_BITS-1:0]   duty_q [N_CH];
  logic [PWM_BITS-1:0]   duty_d [N_CH];
  logic [PR_W-1:0]       presc_q, presc_d;
  logic [BLINK_BITS-1:0] bcnt_q, bcnt_d;
  logic [PWM_BITS-1:0]   pcnt_q, pcnt_d;
  logic [N_CH-1:0]       led_q, led_d;
  logic                  tick_q, tick_d;

  logic                  tick_int;
  logic                  slow, fast;
  logic [31:0]           cfg_ch_ext;

  assign tick_int   = (presc_q == PR_W'(PRESC_DIV - 1));
  assign slow       = bcnt_q[BLINK_BITS-1];
  assign fast       = bcnt_q[BLINK_BITS-2];
  // Zero-extend so indices beyond N_CH never alias onto a real channel.
  assign cfg_ch_ext = 32'(cfg_ch);

  always_comb begin
    mode_d = mode_q;
    duty_d = duty_q;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_we && (cfg_ch_ext == 32'(i))) begin
        mode_d[i] = cfg_mode;
        duty_d[i] = cfg_duty;
      end
    end
  end

  // sync overrides counting and suppresses the tick that would fire this cycle.
  always_comb begin
    presc_d = presc_q + PR_W'(1);
    bcnt_d  = bcnt_q;
    pcnt_d  = pcnt_q + PWM_BITS'(1);
    tick_d  = 1'b0;
    if (sync) begin
      presc_d = '0;
      bcnt_d  = '0;
      pcnt_d  = '0;
    end else if (tick_int) begin
      presc_d = '0;
      bcnt_d  = bcnt_q + BLINK_BITS'(1);
      tick_d  = 1'b1;
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      logic pwm;
      logic f;
      // All-ones duty must be fully lit; pcnt < duty alone would miss one slot.
      pwm = (pcnt_q < duty_q[i]) || (duty_q[i] == '1);
      case (mode_q[i])
        2'd1:    f = pwm;
        2'd2:    f = pwm & slow;
        2'd3:    f = pwm & fast;
        default: f = 1'b0;
      endcase
      led_d[i] = ledOn & f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i] <= 2'd0;
        duty_q[i] <= '1;
      end
      presc_q <= '0;
      bcnt_q  <= '0;
      pcnt_q  <= '0;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      pcnt_q  <= pcnt_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_ctrl_array.sv
module tb_led_ctrl_array;

  logic       clk = 1'b0;
  logic       rst, cfg_we, sync, ledOn;
  logic [1:0] cfg_ch, cfg_mode;
  logic [2:0] cfg_duty;
  logic [3:0] led4;
  logic       tick4;
  logic [2:0] led3;
  logic       tick3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_ctrl_array #(.N_CH(4), .PWM_BITS(3), .PRESC_DIV(4), .BLINK_BITS(3)) u_dut4 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .sync(sync), .ledOn(ledOn), .led(led4), .tick(tick4)
  );

  led_ctrl_array #(.N_CH(3), .PWM_BITS(3), .PRESC_DIV(4), .BLINK_BITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .sync(sync), .ledOn(ledOn), .led(led3), .tick(tick3)
  );

  typedef struct {
    logic       rst, we;
    logic [1:0] ch, mode;
    logic [2:0] duty;
    logic       sync, on;
    logic [3:0] led;
    logic       tick;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(logic r, logic w, logic [1:0] c, logic [1:0] m,
                              logic [2:0] d, logic s, logic o, logic [3:0] l, logic t);
    vec_t v;
    v.rst = r; v.we = w; v.ch = c; v.mode = m; v.duty = d;
    v.sync = s; v.on = o; v.led = l; v.tick = t;
    return v;
  endfunction

  task automatic drive(logic r, logic w, logic [1:0] c, logic [1:0] m,
                       logic [2:0] d, logic s, logic o);
    rst = r; cfg_we = w; cfg_ch = c; cfg_mode = m; cfg_duty = d; sync = s; ledOn = o;
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected led after the s-th edge following a counter restart, with
  // ch0 slow blink, ch1 steady, ch2 steady at duty d2, ch3 fast blink.
  function automatic logic [3:0] exp_led(int s, int d2);
    logic [3:0] r;
    r[0] = ((s - 1) % 32) >= 16;
    r[1] = 1'b1;
    r[2] = (((s - 1) % 8) < d2) || (d2 == 7);
    r[3] = ((s - 1) % 16) >= 8;
    return r;
  endfunction

  initial begin
    int s;
    int d2;
    drive(1'b1, 1'b1, 2'd1, 2'd1, 3'd7, 1'b0, 1'b1);

    // Reset with enable and a pending write: outputs stay dark, write discarded.
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("rst_led[%0d]", i), led4, 4'b0000);
      chk($sformatf("rst_tick[%0d]", i), tick4, 1'b0);
    end
    drive(1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    for (int j = 1; j <= 64; j++) begin
      step();
      chk($sformatf("idle_led[%0d]", j), led4, 4'b0000);
      chk($sformatf("idle_tick[%0d]", j), tick4, (j % 4) == 0);
    end

    // Table: reset, staggered writes, sync, first blink cycles.
    vt[0]  = mk(1, 1, 1, 1, 7, 0, 1, 4'b0000, 0);
    vt[1]  = mk(1, 1, 1, 1, 7, 0, 1, 4'b0000, 0);
    vt[2]  = mk(0, 1, 1, 1, 7, 0, 1, 4'b0000, 0);
    vt[3]  = mk(0, 1, 2, 1, 3, 0, 1, 4'b0010, 0);
    vt[4]  = mk(0, 1, 0, 2, 7, 0, 1, 4'b0110, 0);
    vt[5]  = mk(0, 1, 3, 3, 7, 0, 1, 4'b0010, 1);
    vt[6]  = mk(0, 0, 0, 0, 0, 1, 1, 4'b0010, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 1, 4'b0110, 0);
    vt[8]  = mk(0, 0, 0, 0, 0, 0, 1, 4'b0110, 0);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 1, 4'b0110, 0);
    vt[10] = mk(0, 0, 0, 0, 0, 0, 1, 4'b0010, 1);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 1, 4'b0010, 0);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 1, 4'b0010, 0);
    vt[13] = mk(0, 0, 0, 0, 0, 0, 1, 4'b0010, 0);
    vt[14] = mk(0, 0, 0, 0, 0, 0, 1, 4'b0010, 1);
    vt[15] = mk(0, 0, 0, 0, 0, 0, 1, 4'b1110, 0);
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].rst, vt[i].we, vt[i].ch, vt[i].mode, vt[i].duty, vt[i].sync, vt[i].on);
      step();
      chk($sformatf("vec_led[%0d]", i), led4, vt[i].led);
      chk($sformatf("vec_tick[%0d]", i), tick4, vt[i].tick);
    end

    // Long-run blink/PWM pattern, with a 5-cycle enable drop at s=41..45.
    drive(1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    d2 = 3;
    for (s = 10; s <= 115; s++) begin
      ledOn  = !(s >= 41 && s <= 45);
      cfg_we = (s == 81);
      if (s == 81) begin
        cfg_ch = 2'd2; cfg_mode = 2'd1; cfg_duty = 3'd0;
      end
      step();
      chk($sformatf("run_led[%0d]", s), led4, ledOn ? exp_led(s, d2) : 4'b0000);
      chk($sformatf("run_tick[%0d]", s), tick4, (s % 4) == 0);
      if (s == 81) d2 = 0;
    end

    // Sync on a would-be tick cycle while ch0 is lit: tick suppressed, phase restarts.
    drive(1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1);
    step();
    chk("sync_led", led4, exp_led(116, 0));
    chk("sync_tick", tick4, 1'b0);
    sync = 1'b0;
    for (s = 1; s <= 20; s++) begin
      step();
      chk($sformatf("post_sync_led[%0d]", s), led4, exp_led(s, 0));
      chk($sformatf("post_sync_tick[%0d]", s), tick4, (s % 4) == 0);
    end

    // Reset while ch0 lit, with a competing write: everything returns dark.
    drive(1'b1, 1'b1, 2'd0, 2'd2, 3'd7, 1'b0, 1'b1);
    step();
    chk("midrst_led", led4, 4'b0000);
    chk("midrst_tick", tick4, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    for (int j = 1; j <= 40; j++) begin
      step();
      chk($sformatf("after_rst_led[%0d]", j), led4, 4'b0000);
      chk($sformatf("after_rst_tick[%0d]", j), tick4, (j % 4) == 0);
    end
    drive(1'b0, 1'b1, 2'd0, 2'd1, 3'd7, 1'b0, 1'b1);
    step();
    chk("rewrite_edge_led", led4, 4'b0000);
    cfg_we = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("rewrite_led[%0d]", j), led4, 4'b0001);
    end

    // Out-of-range channel on a 3-channel build leaves every LED unchanged.
    drive(1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    step();
    chk("n3_rst_led", led3, 3'b000);
    drive(1'b0, 1'b1, 2'd0, 2'd1, 3'd7, 1'b0, 1'b1);
    step();
    chk("n3_wr_edge_led", led3, 3'b000);
    drive(1'b0, 1'b1, 2'd3, 2'd1, 3'd7, 1'b0, 1'b1);
    step();
    chk("n3_oor1_led", led3, 3'b001);
    drive(1'b0, 1'b1, 2'd3, 2'd0, 3'd0, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("n3_oor2_led[%0d]", j), led3, 3'b001);
    end
    cfg_we = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("n3_hold_led[%0d]", j), led3, 3'b001);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
